// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory stage.
//   mem_op_e : load/store width and extension codes carried on MemOp
//   state_e  : controller state (clear sweep vs. normal operation)
package data_mem_pkg;

  localparam int unsigned DepthWordsDefault = 3072;

  typedef enum logic [2:0] {
    MemOpW  = 3'b000,  // word
    MemOpHu = 3'b001,  // halfword, zero-extended
    MemOpHs = 3'b010,  // halfword, sign-extended
    MemOpBu = 3'b011,  // byte, zero-extended
    MemOpBs = 3'b100   // byte, sign-extended
  } mem_op_e;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StReady = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem_lane.sv
// Combinational lane logic for the data memory.
//   addr_lo_i  : Addr[1:0], byte offset within the word
//   mem_op_i   : access width / extension code
//   wd_i       : store data (low bits used for half/byte)
//   old_word_i : current contents of the addressed word
//   merged_o   : word to write back for a store (unselected bytes preserved)
//   rd_o       : selected and extended load data
module dm_lane
  import data_mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] old_word_i,
  output logic [31:0] merged_o,
  output logic [31:0] rd_o
);

  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] shifted;

  // Store: replicate the narrow datum across all lanes, then let the
  // byte enables pick which lanes actually change.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (mem_op_i)
      MemOpW: begin
        be    = 4'b1111;
        wdata = wd_i;
      end
      MemOpHu, MemOpHs: begin
        be    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_i[15:0]}};
      end
      MemOpBu, MemOpBs: begin
        be    = 4'b0001 << addr_lo_i;
        wdata = {4{wd_i[7:0]}};
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_o[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word_i[8*i +: 8];
    end
  end

  // Load: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = old_word_i >> {addr_lo_i, 3'b000};
    rd_o    = '0;
    case (mem_op_i)
      MemOpW:  rd_o = shifted;
      MemOpHu: rd_o = {16'h0000, shifted[15:0]};
      MemOpHs: rd_o = {{16{shifted[15]}}, shifted[15:0]};
      MemOpBu: rd_o = {24'h000000, shifted[7:0]};
      MemOpBs: rd_o = {{24{shifted[7]}}, shifted[7:0]};
      default: rd_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory for the pipeline memory stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   Addr         : byte address (ALU result)
//   WD           : store data
//   MemWrite     : store request
//   MemRead      : load request
//   MemOp        : width / extension code (see data_mem_pkg)
//   RD           : load data, zero when no valid load
//   Busy         : high while the post-reset clear sweep runs
//   AddrErr      : misaligned, reserved-op or out-of-range request
module data_mem
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DepthWordsDefault
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  MemOp,
  output logic [31:0] RD,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int unsigned     AddrW     = $clog2(DEPTH_WORDS);
  localparam logic [AddrW-1:0] LastPtr  = AddrW'(DEPTH_WORDS - 1);
  localparam logic [32:0]     ByteLimit = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e           state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;

  logic [AddrW-1:0] idx;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic [31:0]      lane_rd;
  logic             misalign, bad_op, out_of_range, fault, ready, we;

  assign idx      = Addr[AddrW+1:2];
  assign old_word = mem_q[idx];

  dm_lane u_lane (
    .addr_lo_i  (Addr[1:0]),
    .mem_op_i   (MemOp),
    .wd_i       (WD),
    .old_word_i (old_word),
    .merged_o   (merged),
    .rd_o       (lane_rd)
  );

  // Fault detection.
  always_comb begin
    misalign = 1'b0;
    bad_op   = 1'b0;
    case (MemOp)
      MemOpW:           misalign = |Addr[1:0];
      MemOpHu, MemOpHs: misalign = Addr[0];
      MemOpBu, MemOpBs: misalign = 1'b0;
      default:          bad_op   = 1'b1;
    endcase
  end

  assign out_of_range = {1'b0, Addr} >= ByteLimit;
  assign fault        = (MemRead | MemWrite) & (misalign | bad_op | out_of_range);
  assign ready        = (state_q == StReady);
  assign we           = ready & MemWrite & ~fault;

  assign AddrErr = ready & fault;
  assign RD      = (ready & MemRead & ~fault) ? lane_rd : '0;
  assign Busy    = (state_q == StClear);

  // Sweep controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == StClear) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LastPtr) begin
        state_d = StReady;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array itself is not reset; the sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (we) begin
      mem_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  localparam int Depth = 3072;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WD = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [2:0]  MemOp = '0;
  logic [31:0] RD;
  logic        Busy;
  logic        AddrErr;

  int compared = 0;
  int mismatched = 0;

  // Reference model: plain byte-addressed behaviour of the memory.
  logic [31:0] m_mem [Depth];
  int          clear_left = Depth;

  always #5 clk = ~clk;

  data_mem #(.DEPTH_WORDS(Depth)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Addr     (Addr),
    .WD       (WD),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .MemOp    (MemOp),
    .RD       (RD),
    .Busy     (Busy),
    .AddrErr  (AddrErr)
  );

  function automatic int size_of(logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op <= 3'd2) return 2;
    return 1;
  endfunction

  function automatic bit fault_of(logic [2:0] op, logic [31:0] a);
    if (op > 3'd4) return 1'b1;
    return ((a % size_of(op)) != 0) || (a >= 32'(4 * Depth));
  endfunction

  function automatic logic [31:0] load_of(logic [2:0] op, logic [31:0] a);
    logic [31:0] v;
    v = m_mem[a / 4] >> (8 * (a % 4));
    if (size_of(op) == 2) begin
      v = v & 32'h0000_FFFF;
      if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
    end else if (size_of(op) == 1) begin
      v = v & 32'h0000_00FF;
      if (op == 3'd4 && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  task automatic model_step();
    int k;
    if (!reset_n) begin
      clear_left = Depth;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (MemWrite && !fault_of(MemOp, Addr)) begin
      for (int b = 0; b < size_of(MemOp); b++) begin
        k = int'(Addr % 4) + b;
        m_mem[Addr / 4][8*k +: 8] = WD[8*b +: 8];
      end
    end
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Continuous compare of all outputs against the model.
  initial begin
    logic        eb, ee;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (!reset_n || clear_left > 0) begin
        eb = 1'b1; ee = 1'b0; er = '0;
      end else begin
        eb = 1'b0;
        ee = (MemRead || MemWrite) && fault_of(MemOp, Addr);
        er = (MemRead && !ee) ? load_of(MemOp, Addr) : 32'h0;
      end
      check("model Busy", {31'b0, Busy}, {31'b0, eb});
      check("model AddrErr", {31'b0, AddrErr}, {31'b0, ee});
      check("model RD", RD, er);
    end
  end

  task automatic drive(bit w, bit r, logic [2:0] op, logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    #1;
    MemWrite = w;
    MemRead  = r;
    MemOp    = op;
    Addr     = a;
    WD       = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  task automatic count_busy(string name);
    int n = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (!Busy) break;
    end
    check(name, 32'(n), 32'd3072);
  endtask

  task automatic rand_op();
    logic [31:0] a;
    int sel = $urandom_range(0, 99);
    if (sel < 50)      a = $urandom_range(0, 255);
    else if (sel < 80) a = $urandom_range(0, 4 * Depth - 1);
    else if (sel < 90) a = $urandom_range(4 * Depth - 8, 4 * Depth + 8);
    else               a = $urandom;
    drive(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
  endtask

  initial begin
    // Reset and first sweep.
    repeat (3) @(negedge clk);
    #2;
    check("reset Busy", {31'b0, Busy}, 32'd1);
    check("reset RD", RD, 32'h0);
    check("reset AddrErr", {31'b0, AddrErr}, 32'd0);
    reset_n = 1'b1;
    count_busy("sweep length");

    drive(1'b0, 1'b1, 3'd0, 32'h0, 32'h0);       check("rd 0x0", RD, 32'h0);
    drive(1'b0, 1'b1, 3'd0, 32'h2FFC, 32'h0);    check("rd 0x2FFC", RD, 32'h0);

    drive(1'b1, 1'b0, 3'd0, 32'h10, 32'h12345678);
    drive(1'b0, 1'b1, 3'd4, 32'h13, 32'h0);      check("lb 0x13", RD, 32'h00000012);
    drive(1'b0, 1'b1, 3'd1, 32'h10, 32'h0);      check("lhu 0x10", RD, 32'h00005678);

    drive(1'b1, 1'b0, 3'd3, 32'h21, 32'h000000FF);
    drive(1'b0, 1'b1, 3'd0, 32'h20, 32'h0);      check("lw 0x20", RD, 32'h0000FF00);
    drive(1'b0, 1'b1, 3'd4, 32'h21, 32'h0);      check("lb 0x21", RD, 32'hFFFFFFFF);

    drive(1'b1, 1'b0, 3'd0, 32'h22, 32'hDEADBEEF);
    check("sw 0x22 err", {31'b0, AddrErr}, 32'd1);
    drive(1'b0, 1'b1, 3'd1, 32'h23, 32'h0);
    check("lhu 0x23 err", {31'b0, AddrErr}, 32'd1);
    check("lhu 0x23 RD", RD, 32'h0);
    drive(1'b0, 1'b1, 3'd0, 32'h20, 32'h0);      check("lw 0x20 kept", RD, 32'h0000FF00);
    drive(1'b0, 1'b1, 3'd0, 32'h3000, 32'h0);
    check("lw 0x3000 err", {31'b0, AddrErr}, 32'd1);
    drive(1'b0, 1'b1, 3'd5, 32'h20, 32'h0);
    check("reserved op err", {31'b0, AddrErr}, 32'd1);

    drive(1'b1, 1'b0, 3'd0, 32'h40, 32'hAAAAAAAA);
    drive(1'b1, 1'b1, 3'd0, 32'h40, 32'h55555555); check("rw same cycle", RD, 32'hAAAAAAAA);
    drive(1'b0, 1'b1, 3'd0, 32'h40, 32'h0);        check("rw next cycle", RD, 32'h55555555);

    drive(1'b1, 1'b0, 3'd2, 32'h46, 32'h0000BEEF);
    drive(1'b0, 1'b1, 3'd2, 32'h46, 32'h0);        check("lh 0x46", RD, 32'hFFFFBEEF);
    drive(1'b0, 1'b1, 3'd0, 32'h44, 32'h0);        check("lw 0x44", RD, 32'hBEEF0000);

    // Random traffic checked by the compare process.
    repeat (2000) rand_op();

    // Reset, then a second reset pulse 1000 cycles into the sweep.
    idle();
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (1000) rand_op();
    idle();
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    count_busy("resweep length");

    drive(1'b0, 1'b1, 3'd0, 32'h10, 32'h0);      check("cleared 0x10", RD, 32'h0);
    drive(1'b0, 1'b1, 3'd0, 32'h40, 32'h0);      check("cleared 0x40", RD, 32'h0);
    for (int i = 0; i < Depth; i++) drive(1'b0, 1'b1, 3'd0, 32'(4 * i), 32'h0);

    idle();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
